// File: rtl/sram_rw_masked_ext.sv
// Single-port, lane-masked SRAM model with a configurable read latency, a read-valid
// strobe, read-data hold and an optional zeroing sweep after reset.
module sram_rw_masked_ext #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 60,
    parameter int MASK_GRAN      = 6,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          RW0_clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             RW0_addr,
    input  logic                          RW0_en,
    input  logic                          RW0_wmode,
    input  logic [DATA_W/MASK_GRAN-1:0]   RW0_wmask,
    input  logic [DATA_W-1:0]             RW0_wdata,
    output logic [DATA_W-1:0]             RW0_rdata,
    output logic                          RW0_rvalid,
    output logic                          RW0_ready
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MASK_W = DATA_W / MASK_GRAN;

    if (DATA_W % MASK_GRAN != 0) begin : g_bad_gran
        $fatal(1, "sram_rw_masked_ext: DATA_W must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $fatal(1, "sram_rw_masked_ext: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                rd_acc;
    logic                wr_acc;
    logic                clr_we;
    logic [DATA_W-1:0]   rd_word_p0;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Request qualification; reset also blocks array writes so it never disturbs contents.
    always_comb begin
        rd_acc     = RW0_en && ready_q && !RW0_wmode;
        wr_acc     = RW0_en && ready_q &&  RW0_wmode && !reset;
        clr_we     = (state_q == ST_CLEAR) && !reset;
        rd_word_p0 = mem[RW0_addr];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (&cnt_q) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (reset) begin
            state_q  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ready_q  <= (CLEAR_ON_RESET == 0);
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (RW0_wmask[i]) begin
                    mem[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                vld_p1_q;
        logic [DATA_W-1:0]   rdata_p1_q;

        // Stage p1: array word captured at accept; only the valid is flushed by reset.
        always_ff @(posedge RW0_clk) begin
            if (reset) begin
                vld_p1_q <= 1'b0;
            end else begin
                vld_p1_q <= rd_acc;
            end
            rdata_p1_q <= rd_word_p0;
        end

        always_comb begin
            rvalid_d = vld_p1_q;
            rdata_d  = vld_p1_q ? rdata_p1_q : rdata_q;
        end
    end else begin : g_lat1
        always_comb begin
            rvalid_d = rd_acc;
            rdata_d  = rd_acc ? rd_word_p0 : rdata_q;
        end
    end

    assign RW0_rdata  = rdata_q;
    assign RW0_rvalid = rvalid_q;
    assign RW0_ready  = ready_q;

endmodule
